// File: rtl/xintf_pkg.sv
// Shared constants and FSM state type for the XINTF DPBRAM mailbox agent.
package xintf_pkg;

  localparam int unsigned RAM_ADDR_W     = 9;
  localparam int unsigned RAM_DATA_W     = 16;
  localparam int unsigned RAM_WORDS      = 512;
  localparam int unsigned CMD_DEPTH_DEF  = 16;
  localparam int unsigned STAT_DEPTH_DEF = 16;
  localparam int unsigned RD_LAT_DEF     = 2;

  typedef enum logic [2:0] {
    IDLE,
    STAT_WR,
    CMD_RD,
    DRAIN,
    DONE
  } agent_state_e;

endpackage

// File: rtl/xintf_dpbram_agent_if.sv
// PL-side ports of the command (read) and status (write) DPBRAMs.
interface xintf_dpbram_agent_if;
  import xintf_pkg::*;

  logic [RAM_ADDR_W-1:0] o_cmd_ram_addr;
  logic                  o_cmd_ram_ce;
  logic                  o_cmd_ram_we;
  logic [RAM_DATA_W-1:0] o_cmd_ram_din;
  logic [RAM_DATA_W-1:0] i_cmd_ram_dout;

  logic [RAM_ADDR_W-1:0] o_stat_ram_addr;
  logic                  o_stat_ram_ce;
  logic                  o_stat_ram_we;
  logic [RAM_DATA_W-1:0] o_stat_ram_din;
  logic [RAM_DATA_W-1:0] i_stat_ram_dout;

  modport master (
    output o_cmd_ram_addr, o_cmd_ram_ce, o_cmd_ram_we, o_cmd_ram_din,
    input  i_cmd_ram_dout,
    output o_stat_ram_addr, o_stat_ram_ce, o_stat_ram_we, o_stat_ram_din,
    input  i_stat_ram_dout
  );

  modport slave (
    input  o_cmd_ram_addr, o_cmd_ram_ce, o_cmd_ram_we, o_cmd_ram_din,
    output i_cmd_ram_dout,
    input  o_stat_ram_addr, o_stat_ram_ce, o_stat_ram_we, o_stat_ram_din,
    output i_stat_ram_dout
  );

endinterface

// File: rtl/xintf_dpbram_agent.sv
// Mailbox agent: publishes a status snapshot plus sequence word, then mirrors
// the command region into a register image that updates atomically.
module xintf_dpbram_agent
  import xintf_pkg::*;
#(
  parameter int unsigned CMD_BASE   = 0,
  parameter int unsigned CMD_DEPTH  = CMD_DEPTH_DEF,
  parameter int unsigned STAT_BASE  = 0,
  parameter int unsigned STAT_DEPTH = STAT_DEPTH_DEF,
  parameter int unsigned RD_LAT     = RD_LAT_DEF
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [RAM_DATA_W*STAT_DEPTH-1:0] i_stat_data,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_cmd_valid,
  output logic [RAM_DATA_W*CMD_DEPTH-1:0]  o_cmd_data,
  xintf_dpbram_agent_if.master             ram
);

  localparam int unsigned MAX_DEPTH = (STAT_DEPTH > CMD_DEPTH) ? STAT_DEPTH : CMD_DEPTH;
  localparam int unsigned CNT_W     = $clog2(MAX_DEPTH + 1);
  localparam int unsigned IDX_W     = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned SIDX_W    = (STAT_DEPTH > 1) ? $clog2(STAT_DEPTH) : 1;

  // Address-range and latency sanity checks at elaboration.
  if (CMD_BASE + CMD_DEPTH > RAM_WORDS) begin : g_cmd_range_err
    $error("command region exceeds the 9-bit DPBRAM address space");
  end
  if (STAT_BASE + STAT_DEPTH + 1 > RAM_WORDS) begin : g_stat_range_err
    $error("status region plus sequence word exceeds the DPBRAM address space");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_rd_lat_err
    $error("RD_LAT must be 1 or 2");
  end

  agent_state_e state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [RAM_DATA_W-1:0] seq_q;
  logic                  busy_q, done_q, valid_q;

  logic [STAT_DEPTH-1:0][RAM_DATA_W-1:0] stat_q;
  logic [CMD_DEPTH-1:0][RAM_DATA_W-1:0]  shadow_q, shadow_d, img_q;
  logic [RD_LAT-1:0]                     vld_q;
  logic [RD_LAT-1:0][IDX_W-1:0]          idx_q;

  logic [RAM_ADDR_W-1:0] cmd_addr_q, stat_addr_q;
  logic                  cmd_ce_q, stat_ce_q, stat_we_q;
  logic [RAM_DATA_W-1:0] stat_din_q;

  logic unused_stat_dout;

  assign cnt_nxt = cnt_q + CNT_W'(1);

  // Shadow image with the word emerging from the read pipeline merged in.
  always_comb begin
    shadow_d = shadow_q;
    if (vld_q[RD_LAT-1]) begin
      shadow_d[idx_q[RD_LAT-1]] = ram.i_cmd_ram_dout;
    end
  end

  // Refresh sequencer with registered RAM and handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seq_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      stat_q      <= '0;
      shadow_q    <= '0;
      img_q       <= '0;
      vld_q       <= '0;
      idx_q       <= '0;
      cmd_addr_q  <= '0;
      cmd_ce_q    <= 1'b0;
      stat_addr_q <= '0;
      stat_ce_q   <= 1'b0;
      stat_we_q   <= 1'b0;
      stat_din_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      shadow_q <= shadow_d;
      vld_q[0] <= cmd_ce_q;
      idx_q[0] <= IDX_W'(cnt_q);
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end

      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q     <= STAT_WR;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            stat_q      <= i_stat_data;
            stat_addr_q <= RAM_ADDR_W'(STAT_BASE);
            stat_ce_q   <= 1'b1;
            stat_we_q   <= 1'b1;
            stat_din_q  <= i_stat_data[RAM_DATA_W-1:0];
          end
        end
        STAT_WR: begin
          if (cnt_q == CNT_W'(STAT_DEPTH)) begin
            state_q     <= CMD_RD;
            cnt_q       <= '0;
            stat_addr_q <= '0;
            stat_ce_q   <= 1'b0;
            stat_we_q   <= 1'b0;
            stat_din_q  <= '0;
            cmd_addr_q  <= RAM_ADDR_W'(CMD_BASE);
            cmd_ce_q    <= 1'b1;
          end else begin
            cnt_q       <= cnt_nxt;
            stat_addr_q <= RAM_ADDR_W'(STAT_BASE) + RAM_ADDR_W'(cnt_nxt);
            stat_din_q  <= (cnt_nxt == CNT_W'(STAT_DEPTH)) ? seq_q + RAM_DATA_W'(1)
                                                           : stat_q[SIDX_W'(cnt_nxt)];
          end
        end
        CMD_RD: begin
          if (cnt_q == CNT_W'(CMD_DEPTH - 1)) begin
            state_q    <= DRAIN;
            cnt_q      <= '0;
            cmd_addr_q <= '0;
            cmd_ce_q   <= 1'b0;
          end else begin
            cnt_q      <= cnt_nxt;
            cmd_addr_q <= RAM_ADDR_W'(CMD_BASE) + RAM_ADDR_W'(cnt_nxt);
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_W'(RD_LAT - 1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
            img_q   <= shadow_d;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          seq_q   <= seq_q + RAM_DATA_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_cmd_valid = valid_q;
  assign o_cmd_data  = img_q;

  assign ram.o_cmd_ram_addr  = cmd_addr_q;
  assign ram.o_cmd_ram_ce    = cmd_ce_q;
  assign ram.o_cmd_ram_we    = 1'b0;
  assign ram.o_cmd_ram_din   = '0;
  assign ram.o_stat_ram_addr = stat_addr_q;
  assign ram.o_stat_ram_ce   = stat_ce_q;
  assign ram.o_stat_ram_we   = stat_we_q;
  assign ram.o_stat_ram_din  = stat_din_q;

  // Status port read data has no consumer in this agent.
  assign unused_stat_dout = ^ram.i_stat_ram_dout;

endmodule
